// File: rtl/idma_lane_buffer_pkg.sv
// iDMA lane buffer shared types and sizing helpers.
// Optional fall-through mode: IDMA_LANE_BUFFER_FALL_THROUGH_EN.
package idma_lane_buffer_pkg;

  typedef logic [7:0] byte_t;

  // Pointer width, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must hold the value Depth itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/idma_lane_buffer_fifo.sv
// Single byte-lane FIFO with flush and optional fall-through.
// Fall-through enabled by IDMA_LANE_BUFFER_FALL_THROUGH_EN.
module idma_lane_fifo
  import idma_lane_buffer_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  input  byte_t in_data_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  output byte_t out_data_o,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output logic  full_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(Depth - 1);
  localparam cnt_t FullCnt = cnt_t'(Depth);

  byte_t mem_q [Depth];
  ptr_t  wptr_q, wptr_d;
  ptr_t  rptr_q, rptr_d;
  cnt_t  cnt_q, cnt_d;
  logic  empty;
  logic  push;
  logic  pop;
  logic  store;
  logic  fetch;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  // Handshake outputs and the store/fetch decision for this cycle.
  always_comb begin
    empty      = (cnt_q == '0);
    in_ready_o = (cnt_q != FullCnt);
    full_o     = ~in_ready_o;
    push       = in_valid_i & in_ready_o;
`ifdef IDMA_LANE_BUFFER_FALL_THROUGH_EN
    out_valid_o = ~empty | in_valid_i;
    if (!empty) begin
      out_data_o = mem_q[rptr_q];
    end else if (in_valid_i) begin
      out_data_o = in_data_i;
    end else begin
      out_data_o = '0;
    end
    pop   = out_valid_o & out_ready_i;
    // A byte popped straight off the input never lands in storage.
    store = push & ~(empty & pop);
    fetch = pop & ~empty;
`else
    out_valid_o = ~empty;
    out_data_o  = empty ? '0 : mem_q[rptr_q];
    pop         = out_valid_o & out_ready_i;
    store       = push;
    fetch       = pop;
`endif
  end

  // Pointer and occupancy next-state; flush wins over traffic.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (store) wptr_d = ptr_inc(wptr_q);
      if (fetch) rptr_d = ptr_inc(rptr_q);
      case ({store, fetch})
        2'b10:   cnt_d = cnt_q + cnt_t'(1);
        2'b01:   cnt_d = cnt_q - cnt_t'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Byte storage; contents survive reset, only pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i && store) begin
      mem_q[wptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/idma_lane_buffer.sv
// Per-byte-lane buffer between iDMA read and write stages.
// Optional fall-through mode: IDMA_LANE_BUFFER_FALL_THROUGH_EN.
module idma_lane_buffer
  import idma_lane_buffer_pkg::*;
#(
  parameter int unsigned StrbWidth = 16,
  parameter int unsigned Depth     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  byte_t [StrbWidth-1:0] in_data_i,
  input  logic  [StrbWidth-1:0] in_valid_i,
  output logic  [StrbWidth-1:0] in_ready_o,
  output byte_t [StrbWidth-1:0] out_data_o,
  output logic  [StrbWidth-1:0] out_valid_o,
  input  logic  [StrbWidth-1:0] out_ready_i,
  output logic                  empty_o,
  output logic  [StrbWidth-1:0] full_o
);

  for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
    idma_lane_fifo #(
      .Depth(Depth)
    ) i_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .in_data_i  (in_data_i[i]),
      .in_valid_i (in_valid_i[i]),
      .in_ready_o (in_ready_o[i]),
      .out_data_o (out_data_o[i]),
      .out_valid_o(out_valid_o[i]),
      .out_ready_i(out_ready_i[i]),
      .full_o     (full_o[i])
    );
  end

  // Buffer is clean once no lane holds a byte.
  always_comb begin
    empty_o = ~|out_valid_o;
  end

endmodule

// File: tb/tb_idma_lane_buffer.sv
// Scoreboard bench for idma_lane_buffer, 4 lanes x depth 3.
// Honours IDMA_LANE_BUFFER_FALL_THROUGH_EN when defined.
module tb_idma_lane_buffer;

  localparam int unsigned SW = 4;
  localparam int unsigned DP = 3;
`ifdef IDMA_LANE_BUFFER_FALL_THROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic          clear_i;
  logic [31:0]   in_data_i;
  logic [SW-1:0] in_valid_i;
  logic [SW-1:0] in_ready_o;
  logic [31:0]   out_data_o;
  logic [SW-1:0] out_valid_o;
  logic [SW-1:0] out_ready_i;
  logic          empty_o;
  logic [SW-1:0] full_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]    q [SW][$];
  logic [SW-1:0] popped = '0;
  logic [SW-1:0] byp    = '0;

  idma_lane_buffer #(
    .StrbWidth(SW),
    .Depth    (DP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endfunction

  // Monitor: compare DUT against model queues, pop on handshake.
  always @(negedge clk) begin
    logic [SW-1:0] ev, er, ef;
    logic [31:0]   ed;
    int            sz;
    if (!rst_i) begin
      ev = '0; er = '0; ef = '0; ed = '0;
      for (int i = 0; i < SW; i++) begin
        sz = q[i].size();
        er[i] = (sz < DP);
        ef[i] = (sz == DP);
        if (sz > 0) begin
          ev[i] = 1'b1;
          ed[8*i +: 8] = q[i][0];
        end else if (FT && in_valid_i[i]) begin
          ev[i] = 1'b1;
          ed[8*i +: 8] = in_data_i[8*i +: 8];
        end
      end
      chk("mon_valid", 32'(out_valid_o), 32'(ev));
      chk("mon_data", out_data_o, ed);
      chk("mon_ready", 32'(in_ready_o), 32'(er));
      chk("mon_full", 32'(full_o), 32'(ef));
      chk("mon_empty", 32'(empty_o), 32'(ev == '0));
      for (int i = 0; i < SW; i++) begin
        if (ev[i] && out_ready_i[i]) begin
          if (q[i].size() > 0) begin
            void'(q[i].pop_front());
            popped[i] = 1'b1;
          end else begin
            byp[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid_i  = '0;
    out_ready_i = '0;
    clear_i     = 1'b0;
  endtask

  // One clock of stimulus; accepted pushes go into the model queues.
  task automatic cyc(input logic [SW-1:0] v, input logic [31:0] d,
                     input logic [SW-1:0] r, input logic clr);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    clear_i     = clr;
    @(posedge clk);
    for (int i = 0; i < SW; i++) begin
      if (clr) begin
        q[i].delete();
      end else if (v[i] && !byp[i] &&
                   (q[i].size() + int'(popped[i])) < DP) begin
        q[i].push_back(d[8*i +: 8]);
      end
    end
    popped = '0;
    byp    = '0;
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < SW; i++) q[i].delete();
    popped = '0;
    byp    = '0;
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    in_data_i = '0;
    idle_inputs();
    do_reset();

    // Reset state
    cyc('0, '0, '0, 0);
    chk("rst_ready", 32'(in_ready_o), 32'hF);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_empty", 32'(empty_o), 32'h1);
    chk("rst_full", 32'(full_o), 32'h0);
    chk("rst_data", out_data_o, 32'h0);

    // Misaligned push on lanes 3,2
    cyc(4'b1100, 32'hAABB_0000, '0, 0);
    chk("p_valid", 32'(out_valid_o), 32'hC);
    chk("p_d3", 32'(out_data_o[31:24]), 32'hAA);
    chk("p_d2", 32'(out_data_o[23:16]), 32'hBB);
    chk("p_empty", 32'(empty_o), 32'h0);
    cyc('0, '0, 4'b0100, 0);
    chk("pop2_valid", 32'(out_valid_o), 32'h8);
    chk("pop2_d3", 32'(out_data_o[31:24]), 32'hAA);
    cyc('0, '0, 4'b1000, 0);
    chk("pop3_empty", 32'(empty_o), 32'h1);

    // Lane 0 fill, overflow attempt, drain
    cyc(4'b0001, 32'h01, '0, 0);
    cyc(4'b0001, 32'h02, '0, 0);
    cyc(4'b0001, 32'h03, '0, 0);
    chk("l0_full", 32'(full_o[0]), 32'h1);
    chk("l0_ready", 32'(in_ready_o[0]), 32'h0);
    cyc(4'b0001, 32'h04, '0, 0);
    chk("l0_head1", 32'(out_data_o[7:0]), 32'h01);
    cyc('0, '0, 4'b0001, 0);
    chk("l0_head2", 32'(out_data_o[7:0]), 32'h02);
    cyc('0, '0, 4'b0001, 0);
    chk("l0_head3", 32'(out_data_o[7:0]), 32'h03);
    cyc('0, '0, 4'b0001, 0);
    chk("l0_drained", 32'(out_valid_o[0]), 32'h0);

    // Lane 1 pointer wrap at steady count 2
    cyc(4'b0010, 32'h1000, '0, 0);
    cyc(4'b0010, 32'h1100, '0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(4'b0010, {16'h0, 8'(8'h12 + k), 8'h0}, 4'b0010, 0);
      chk("wr_valid", 32'(out_valid_o[1]), 32'h1);
      chk("wr_full", 32'(full_o[1]), 32'h0);
      chk("wr_head", 32'(out_data_o[15:8]), 32'(8'h10 + k + 1));
    end
    cyc('0, '0, 4'b0010, 0);
    cyc('0, '0, 4'b0010, 0);
    chk("wr_drained", 32'(out_valid_o[1]), 32'h0);

    // Flush beats a simultaneous push
    cyc(4'b1001, 32'h4400_0033, '0, 0);
    cyc(4'b0100, 32'h0055_0000, '0, 1);
    chk("clr_empty", 32'(empty_o), 32'h1);
    chk("clr_valid", 32'(out_valid_o), 32'h0);
    cyc('0, '0, '0, 0);
    chk("clr_lost", 32'(out_valid_o[2]), 32'h0);

    // Reset mid-transfer
    cyc(4'b0011, 32'h7766, '0, 0);
    do_reset();
    chk("mrst_empty", 32'(empty_o), 32'h1);
    chk("mrst_ready", 32'(in_ready_o), 32'hF);

`ifdef IDMA_LANE_BUFFER_FALL_THROUGH_EN
    // Same-cycle bypass on empty lane 0
    in_valid_i  = 4'b0001;
    in_data_i   = 32'h5A;
    out_ready_i = 4'b0001;
    #2;
    chk("ft_valid", 32'(out_valid_o[0]), 32'h1);
    chk("ft_data", 32'(out_data_o[7:0]), 32'h5A);
    cyc(4'b0001, 32'h5A, 4'b0001, 0);
    chk("ft_stay_empty", 32'(out_valid_o[0]), 32'h0);
`endif

    repeat (3) cyc('0, '0, '0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
